// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_writer
// Purpose  : Writes a ROWS x COLS character frame to an HD44780-style LCD
//            (optional clear, per-row set-address, then data bytes).
// Options  : LCD_HEX_FIELD_EN - adds hex_val; 0x7F bytes become hex digits.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module lcd_frame_writer #(
    parameter int ROWS     = 2,
    parameter int COLS     = 16,
    parameter int EN_PULSE = 20,
    parameter int T_CHAR   = 2500,
    parameter int T_CLEAR  = 100000,
    parameter int CNT_W    = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_done,
    input  logic                   start,
    input  logic                   clear_first,
    input  logic [ROWS*COLS*8-1:0] frame,
`ifdef LCD_HEX_FIELD_EN
    input  logic [15:0]            hex_val,
`endif
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_en,
    output logic [7:0]             lcd_data
);

    localparam int FW = ROWS * COLS * 8;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(FW);

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_PULSE     = 3'd3,
        S_WAIT      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_CLEAR   = 2'd0,
        K_ROWADDR = 2'd1,
        K_DATA    = 2'd2
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef LCD_HEX_FIELD_EN
    logic [15:0]      hex_q, hex_d;
    logic [2:0]       nib_q, nib_d;
    logic [3:0]       nib_val;
`endif

    logic             load;
    logic             last;
    logic [CNT_W-1:0] wait_lim;
    int               k;
    logic [IW-1:0]    sel;
    logic [7:0]       ch;
    logic [7:0]       base;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        rs_d     = rs_q;
        data_d   = data_q;
        done_d   = 1'b0;
        load     = 1'b0;
        last     = 1'b0;
`ifdef LCD_HEX_FIELD_EN
        hex_d    = hex_q;
        nib_d    = nib_q;
        nib_val  = 4'h0;
`endif
        wait_lim = (kind_q == K_CLEAR) ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CHAR - 1);

        case (state_q)
            S_WAIT_INIT: begin
                if (init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!init_done) begin
                    state_d = S_WAIT_INIT;
                end else if (start && ready_q) begin
                    frame_d = frame;
`ifdef LCD_HEX_FIELD_EN
                    hex_d   = hex_val;
                    nib_d   = 3'd0;
`endif
                    kind_d  = clear_first ? K_CLEAR : K_ROWADDR;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                    load    = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(EN_PULSE - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_lim) begin
                    cnt_d = '0;
                    case (kind_q)
                        K_CLEAR: begin
                            kind_d = K_ROWADDR;
                            row_d  = '0;
                        end
                        K_ROWADDR: begin
                            kind_d = K_DATA;
                            col_d  = '0;
                        end
                        default: begin
                            if (col_q != CW'(COLS - 1)) begin
                                col_d = col_q + CW'(1);
                            end else if (row_q != RW'(ROWS - 1)) begin
                                kind_d = K_ROWADDR;
                                row_d  = row_q + RW'(1);
                            end else begin
                                last = 1'b1;
                            end
                        end
                    endcase
                    if (last) begin
                        state_d = init_done ? S_IDLE : S_WAIT_INIT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        load    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_WAIT_INIT;
        endcase

        // Bus value is built from the step being entered so it is valid in SETUP.
        k   = int'(row_d) * COLS + int'(col_d);
        sel = IW'(FW - 8 - 8 * k);
        ch  = frame_d[sel +: 8];
        case (int'(row_d))
            0:       base = 8'h00;
            1:       base = 8'h40;
            2:       base = 8'(COLS);
            default: base = 8'(64 + COLS);
        endcase

        if (load) begin
            rs_d = (kind_d == K_DATA);
            case (kind_d)
                K_CLEAR:   data_d = 8'h01;
                K_ROWADDR: data_d = 8'h80 | base;
                default: begin
                    data_d = ch;
`ifdef LCD_HEX_FIELD_EN
                    if (ch == 8'h7F) begin
                        if (nib_d < 3'd4) begin
                            nib_val = 4'(hex_d >> (12 - 4 * int'(nib_d)));
                            data_d  = (nib_val < 4'd10) ? 8'h30 + {4'h0, nib_val}
                                                        : 8'h37 + {4'h0, nib_val};
                            nib_d   = nib_d + 3'd1;
                        end else begin
                            data_d = 8'h3F;
                        end
                    end
`endif
                end
            endcase
        end

        en_d    = (state_d == S_PULSE);
        busy_d  = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_WAIT);
        ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_INIT;
            kind_q  <= K_CLEAR;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LCD_HEX_FIELD_EN
            hex_q   <= 16'h0000;
            nib_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LCD_HEX_FIELD_EN
            hex_q   <= hex_d;
            nib_q   <= nib_d;
`endif
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_q;
    assign lcd_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_frame_writer
// Purpose  : Self-checking bench for lcd_frame_writer against a frame-level
//            model of the expected LCD transfer list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_writer;

    localparam int ROWS     = 2;
    localparam int COLS     = 16;
    localparam int EN_PULSE = 2;
    localparam int T_CHAR   = 5;
    localparam int T_CLEAR  = 20;
    localparam int FW       = ROWS * COLS * 8;
    localparam int XFER     = 1 + EN_PULSE + T_CHAR;
    localparam int CYC_NOCLR = ROWS * (COLS + 1) * XFER;
    localparam int CYC_CLR   = (1 + EN_PULSE + T_CLEAR) + CYC_NOCLR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic          start = 1'b0;
    logic          clear_first = 1'b0;
    logic [FW-1:0] frame_s = '0;
    logic [15:0]   hex_val = 16'h0000;
    logic          ready, busy, done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]    lcd_data;

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .ROWS(ROWS), .COLS(COLS), .EN_PULSE(EN_PULSE),
        .T_CHAR(T_CHAR), .T_CLEAR(T_CLEAR), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .start(start),
        .clear_first(clear_first), .frame(frame_s),
`ifdef LCD_HEX_FIELD_EN
        .hex_val(hex_val),
`endif
        .ready(ready), .busy(busy), .done(done), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
    );

    int total = 0;
    int bad   = 0;

    // Transfer log: {rs,data} per enable pulse, its width, and bus stability
    logic [8:0] got_q[$];
    int         wid_q[$];
    bit         stab_q[$];
    logic [8:0] exp_q[$];

    logic       mon_prev = 1'b0;
    logic [8:0] mon_cur  = '0;
    int         mon_w    = 0;
    bit         mon_stab = 1'b1;

    always @(negedge clk) begin
        if (lcd_en === 1'b1) begin
            if (!mon_prev) begin
                mon_cur  = {lcd_rs, lcd_data};
                mon_w    = 1;
                mon_stab = 1'b1;
            end else begin
                mon_w = mon_w + 1;
                if ({lcd_rs, lcd_data} !== mon_cur) mon_stab = 1'b0;
            end
        end else if (mon_prev) begin
            got_q.push_back(mon_cur);
            wid_q.push_back(mon_w);
            stab_q.push_back(mon_stab);
        end
        mon_prev = (lcd_en === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Frame-level model: expected transfer list straight from the frame rules
    task automatic build_expected(input logic [FW-1:0] fr, input bit clr, input logic [15:0] hv);
        int         hexcnt;
        int         base;
        logic [7:0] b;
        logic [3:0] nb;
        exp_q.delete();
        hexcnt = 0;
        nb     = hv[3:0];
        if (clr) exp_q.push_back({1'b0, 8'h01});
        for (int r = 0; r < ROWS; r++) begin
            base = ((r % 2) * 64) + ((r / 2) * COLS);
            exp_q.push_back({1'b0, 8'(128 + base)});
            for (int c = 0; c < COLS; c++) begin
                b = fr[FW - 1 - 8 * (r * COLS + c) -: 8];
`ifdef LCD_HEX_FIELD_EN
                if (b == 8'h7F) begin
                    if (hexcnt < 4) begin
                        nb = hv[15 - 4 * hexcnt -: 4];
                        b  = (nb < 10) ? 8'(48 + nb) : 8'(55 + nb);
                    end else begin
                        b = 8'h3F;
                    end
                    hexcnt++;
                end
`endif
                exp_q.push_back({1'b1, b});
            end
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 8; i++) f[FW - 1 - 8 * i -: 8] = 8'($urandom_range(32, 126));
        return f;
    endfunction

    // Results of the most recent run_frame call
    int r_cyc, r_ndone;
    bit r_rdy_done, r_busy_done, r_rdy_after, r_extra_busy;

    task automatic run_frame(input logic [FW-1:0] fr, input bit clr, input logic [15:0] hv,
                             input int mid_at, input bit start_on_done);
        int i;
        r_cyc = -1; r_ndone = 0; r_extra_busy = 1'b0;
        r_rdy_done = 1'bx; r_busy_done = 1'bx; r_rdy_after = 1'bx;
        i = 0;
        while (ready !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        got_q.delete(); wid_q.delete(); stab_q.delete();
        frame_s = fr; clear_first = clr; hex_val = hv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (done !== 1'b1 && i < 2000) begin
            start = (i == mid_at);
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        if (done === 1'b1) begin
            r_cyc = i; r_ndone = 1;
            r_rdy_done = ready; r_busy_done = busy;
            start = start_on_done;
            @(negedge clk);
            start = 1'b0;
            r_rdy_after = ready;
            repeat (30) begin
                @(negedge clk);
                if (done === 1'b1) r_ndone++;
                if (busy === 1'b1) r_extra_busy = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_done = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({ready, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {ready, busy, done}); end
        total++; if ({lcd_rs, lcd_rw, lcd_en} !== 3'b000) begin bad++; $display("FAIL reset_lcd_ctrl: got %b want 000", {lcd_rs, lcd_rw, lcd_en}); end
        total++; if (lcd_data !== 8'h00) begin bad++; $display("FAIL reset_lcd_data: got %h want 00", lcd_data); end
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL no_init_ready: got %b want 0", ready); end
        total++; if (got_q.size() !== 0 || lcd_en !== 1'b0) begin bad++; $display("FAIL no_init_en: got %0d pulses want 0", got_q.size()); end
        init_done = 1'b1;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_early: got %b want 0", ready); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_rise: got %b want 1", ready); end
    endtask

    task automatic test_clear_frame();
        logic [FW-1:0] fr;
        fr = "LOAD      [0000]Carrega Valor   ";
        build_expected(fr, 1'b1, 16'h0000);
        run_frame(fr, 1'b1, 16'h0000, -1, 1'b0);
        total++; if (r_cyc !== CYC_CLR) begin bad++; $display("FAIL clr_latency: got %0d want %0d", r_cyc, CYC_CLR); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL clr_done_count: got %0d want 1", r_ndone); end
        total++; if ({r_rdy_done, r_busy_done} !== 2'b00) begin bad++; $display("FAIL clr_done_cycle: ready,busy got %b want 00", {r_rdy_done, r_busy_done}); end
        total++; if (r_rdy_after !== 1'b1) begin bad++; $display("FAIL clr_ready_after: got %b want 1", r_rdy_after); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL clr_xfer_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if ({got_q[i], wid_q[i], stab_q[i]} !== {exp_q[i], EN_PULSE, 1'b1}) begin
                bad++; $display("FAIL clr_xfer[%0d]: got %h w=%0d stable=%0d want %h w=%0d", i, got_q[i], wid_q[i], stab_q[i], exp_q[i], EN_PULSE);
            end
        end
    endtask

    task automatic test_no_clear();
        logic [FW-1:0] fr;
        logic [15:0]   hv;
        fr = rand_frame();
        hv = 16'($urandom);
        build_expected(fr, 1'b0, hv);
        run_frame(fr, 1'b0, hv, -1, 1'b0);
        total++; if (r_cyc !== CYC_NOCLR) begin bad++; $display("FAIL noclr_latency: got %0d want %0d", r_cyc, CYC_NOCLR); end
        total++; if (got_q.size() == 0 || got_q[0] !== 9'h080) begin bad++; $display("FAIL noclr_first: got %h want 080", (got_q.size() > 0) ? got_q[0] : 9'h1FF); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL noclr_xfer_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if ({got_q[i], wid_q[i], stab_q[i]} !== {exp_q[i], EN_PULSE, 1'b1}) begin
                bad++; $display("FAIL noclr_xfer[%0d]: got %h w=%0d stable=%0d want %h w=%0d", i, got_q[i], wid_q[i], stab_q[i], exp_q[i], EN_PULSE);
            end
        end
    endtask

    task automatic test_ignored_starts();
        logic [FW-1:0] fr;
        bit            clr;
        int            want;
        fr  = rand_frame();
        clr = 1'($urandom);
        want = clr ? CYC_CLR : CYC_NOCLR;
        build_expected(fr, clr, 16'h1234);
        run_frame(fr, clr, 16'h1234, $urandom_range(20, 200), 1'b1);
        total++; if (r_cyc !== want) begin bad++; $display("FAIL ign_latency: got %0d want %0d", r_cyc, want); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", r_ndone); end
        total++; if (r_extra_busy !== 1'b0) begin bad++; $display("FAIL ign_restart: busy after done got %b want 0", r_extra_busy); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ign_xfer_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ign_xfer[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [FW-1:0] fr;
        int            rises, i, dones;
        bit            prev;
        bit            clr;
        rises = 0; i = 0; dones = 0; prev = 1'b0;
        while (ready !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        frame_s = rand_frame(); clear_first = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        // Seventh pulse: row-0 address, then characters 0..5
        while (rises < 7 && i < 500) begin
            @(negedge clk);
            if (lcd_en === 1'b1 && !prev) rises++;
            if (done === 1'b1) dones++;
            prev = (lcd_en === 1'b1);
            i++;
        end
        total++; if (rises !== 7 || lcd_en !== 1'b1) begin bad++; $display("FAIL rst_reach_char5: pulses got %0d want 7", rises); end
        rst_n = 1'b0;
        #1;
        total++; if (lcd_en !== 1'b0) begin bad++; $display("FAIL rst_en_async: got %b want 0", lcd_en); end
        total++; if ({ready, busy, dones[0]} !== 3'b000) begin bad++; $display("FAIL rst_flags: ready,busy,done got %b want 000", {ready, busy, dones[0]}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fr  = rand_frame();
        clr = 1'($urandom);
        build_expected(fr, clr, 16'hBEEF);
        run_frame(fr, clr, 16'hBEEF, -1, 1'b0);
        total++; if (r_cyc !== (clr ? CYC_CLR : CYC_NOCLR)) begin bad++; $display("FAIL rst_recover_latency: got %0d want %0d", r_cyc, clr ? CYC_CLR : CYC_NOCLR); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_recover_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            total++;
            if (got_q[j] !== exp_q[j]) begin
                bad++; $display("FAIL rst_recover_xfer[%0d]: got %h want %h", j, got_q[j], exp_q[j]);
            end
        end
    endtask

    task automatic test_hex_field();
        logic [FW-1:0] fr;
        logic [8:0]    want [5];
        int            idx  [5];
        fr = rand_frame();
        for (int k = 11; k <= 14; k++) fr[FW - 1 - 8 * k -: 8] = 8'h7F;
        fr[FW - 1 - 8 * 20 -: 8] = 8'h7F;
        // Bus positions: row-0 address precedes bytes 0..15, row-1 address precedes 16..31
        idx = '{12, 13, 14, 15, 22};
`ifdef LCD_HEX_FIELD_EN
        want = '{9'h133, 9'h141, 9'h137, 9'h146, 9'h13F};
`else
        want = '{9'h17F, 9'h17F, 9'h17F, 9'h17F, 9'h17F};
`endif
        build_expected(fr, 1'b0, 16'h3A7F);
        run_frame(fr, 1'b0, 16'h3A7F, -1, 1'b0);
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL hex_xfer_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int j = 0; j < 5; j++) begin
            total++;
            if (got_q.size() <= idx[j] || got_q[idx[j]] !== want[j]) begin
                bad++; $display("FAIL hex_digit[%0d]: got %h want %h", idx[j], (got_q.size() > idx[j]) ? got_q[idx[j]] : 9'h1FF, want[j]);
            end
        end
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            total++;
            if (got_q[j] !== exp_q[j]) begin
                bad++; $display("FAIL hex_xfer[%0d]: got %h want %h", j, got_q[j], exp_q[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_frame();
        test_no_clear();
        test_ignored_starts();
        test_reset_mid_pulse();
        test_hex_field();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
